db_multi: RTL
=============

# db_multi

Multi-channel, parametrised debouncer for the slot-machine front panel. It replaces single-input, fixed-period debouncing with the following:
- one shared sample-tick prescaler for all channels;
- per-channel two-flop synchronisers;
- a programmable count of consecutive agreeing samples before the output changes;
- one-cycle rising and falling edge pulses per channel.

It sits between the raw button/switch pins and the game-control FSM. The FSM consumes `db_out` for level sensing and `rise_pulse` for single-shot actions such as spin, bet and mode.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent inputs; must be ≥1.
- `CLK_DIV`, 100000: sample-tick period in `clk` cycles; must be ≥2.
- `STABLE_SAMPLES`, 4: consecutive differing samples required to change output; must be ≥1.
- `RESET_LEVEL`, 0: reset value of synchronisers and `db_out`; all channels take this value.

Ports:
- `clk`  in  1  system clock. There is one clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `raw_in`  in  CHANNELS  asynchronous raw inputs.
- `db_out`  out  CHANNELS  debounced levels (registered).
- `rise_pulse`  out  CHANNELS  one-cycle pulse when `db_out[i]` goes 0→1.
- `fall_pulse`  out  CHANNELS  one-cycle pulse when `db_out[i]` goes 1→0.
- `sample_tick`  out  1  registered prescaler strobe, one cycle high every CLK_DIV cycles.

## Operation
- **Prescaler**
  - `div_cnt` is $clog2(CLK_DIV) bits and counts 0..CLK_DIV-1, then wraps to 0.
  - `sample_tick` is registered high on the clock edge where `div_cnt` wraps, and low otherwise.
- **Synchroniser:** per channel, `s1 <= raw_in[i]`, then `s2 <= s1`. Only `s2` is used downstream.
- **Per-channel state:** `stab_cnt[i]` is max(1,$clog2(STABLE_SAMPLES)) bits. All channels are evaluated only on cycles where `sample_tick` == 1:
  - If `s2 == db_out[i]`: `stab_cnt <= 0`. This is a bounce or no change.
  - Else if `stab_cnt == STABLE_SAMPLES-1`: `db_out[i] <= s2`, `stab_cnt <= 0`, and the matching edge pulse is set.
  - Else: `stab_cnt <= stab_cnt + 1`.
  - The counter never exceeds STABLE_SAMPLES-1, so there is no wrap.
- **Edge pulses**
  - `rise_pulse[i]`/`fall_pulse[i]` are registered and high for exactly the one cycle in which the new `db_out[i]` value first appears. They are cleared on every other cycle.
  - `rise_pulse[i]` and `fall_pulse[i]` are never both high.
- **Channel independence:** channels are fully independent. Several channels may update and pulse on the same tick.
- **No tick, no change:** with `sample_tick` low, `db_out` and `stab_cnt` hold regardless of `raw_in`.

## Timing
- **Reset values:** `rst_n` low asynchronously forces:
  - `div_cnt` = 0, `sample_tick` = 0;
  - `s1`, `s2`, `db_out` = RESET_LEVEL;
  - `stab_cnt` = 0;
  - `rise_pulse` = `fall_pulse` = 0.
- **Reset mid-operation:** a partially counted change is discarded and no pulse is emitted.
- **First tick:** the first `sample_tick` is high in cycle CLK_DIV after `rst_n` deassertion, counting the first post-reset edge as cycle 1. Later ticks follow every CLK_DIV cycles.
- **Synchroniser latency:** 2 cycles from `raw_in` change to `s2`.
- **Output latency:** for a clean step, `db_out` changes on the STABLE_SAMPLES-th tick whose `s2` differs from `db_out`. Worst-case latency is 2 + CLK_DIV·STABLE_SAMPLES cycles.
- **STABLE_SAMPLES = 1:** the output follows `s2` on the first differing tick.
- **Bounce rejection:** a single agreeing sample inside the window restarts the count from 0.
- **Pulses in the same tick:** a pulse is produced in the same registered update as `db_out`. A pulse ends before the next tick, since CLK_DIV ≥ 2.
- **Glitches between ticks:** a `raw_in` glitch shorter than CLK_DIV cycles that does not coincide with a tick is invisible.

## Test plan
Bench parameters: CHANNELS=4, CLK_DIV=4, STABLE_SAMPLES=3, RESET_LEVEL=0.
- **Reset:** hold `rst_n`=0 with `raw_in`=4'hF → `db_out`=0, both pulse vectors 0, `sample_tick`=0. Release → first `sample_tick` at cycle 4, then at cycles 8, 12, …
- **Clean press:** `raw_in[0]` 0→1 and held → `db_out[0]`=1 on the third tick after `s2` goes high. `rise_pulse[0]` is high for that single cycle. `fall_pulse`=0 and other channels are unchanged.
- **Bounce:** `raw_in[1]` high for 2 ticks, low for 1 tick, then high → no change until 3 further consecutive high ticks. Exactly one `rise_pulse[1]`.
- **Release and simultaneity:** `raw_in` = 4'b1111 held, then 4'b0101 held → `db_out` goes 4'b1111 then 4'b0101. `fall_pulse` = 4'b1010 for one cycle on the same tick.
- **Short glitch:** `raw_in[3]` pulsed high for 2 cycles between ticks → `db_out[3]` stays 0 and no pulses.
- **Reset mid-count:** `raw_in[2]` high for 2 ticks, then `rst_n` low for 1 cycle, then released → `db_out[2]` stays 0 until 3 full ticks after release, followed by a single `rise_pulse[2]`.

Source files
------------

// File: rtl/db_multi.sv
// db_multi - multi-channel debouncer for the slot-machine front panel.
//
// All channels share one sample-tick prescaler. Each raw input goes through
// a two-flop synchroniser. A channel's debounced level changes only after
// STABLE_SAMPLES consecutive sample ticks disagree with the current level.
// Each level change also emits a one-cycle rise or fall pulse.
//
// Ports:
//   clk          system clock (single clock domain)
//   rst_n        asynchronous active-low reset
//   raw_in       [CHANNELS] raw, asynchronous button/switch inputs
//   db_out       [CHANNELS] debounced levels (registered)
//   rise_pulse   [CHANNELS] one-cycle pulse when db_out[i] goes 0->1
//   fall_pulse   [CHANNELS] one-cycle pulse when db_out[i] goes 1->0
//   sample_tick  registered strobe, high one cycle every CLK_DIV cycles

module db_multi #(
  parameter int CHANNELS       = 4,
  parameter int CLK_DIV        = 100000,
  parameter int STABLE_SAMPLES = 4,
  parameter bit RESET_LEVEL    = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                sample_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = (STABLE_SAMPLES > 2) ? $clog2(STABLE_SAMPLES) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [CHANNELS-1:0] RST_VEC  = {CHANNELS{RESET_LEVEL}};

  logic [DIV_W-1:0]    div_cnt;
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CNT_W-1:0]    stab_cnt [CHANNELS];

  // The tick is registered on the wrap edge. The first tick is therefore
  // visible in cycle CLK_DIV after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      sample_tick <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt     <= '0;
      sample_tick <= 1'b1;
    end else begin
      div_cnt     <= div_cnt + DIV_W'(1);
      sample_tick <= 1'b0;
    end
  end

  // Two-flop synchroniser. Only s2 is used past this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VEC;
      s2 <= RST_VEC;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Per-channel agreement counters. Any sample that matches the current
  // level restarts the count, so a single bounce throws away the window.
  // Pulses default low each cycle, so each pulse lasts exactly the cycle
  // in which the new level first appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_out     <= RST_VEC;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      if (sample_tick) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (s2[i] == db_out[i]) begin
            stab_cnt[i] <= '0;
          end else if (stab_cnt[i] == CNT_LAST) begin
            db_out[i]     <= s2[i];
            stab_cnt[i]   <= '0;
            rise_pulse[i] <= s2[i];
            fall_pulse[i] <= ~s2[i];
          end else begin
            stab_cnt[i] <= stab_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
